// File: rtl/sin_pkg.sv
// Shared constants and state encoding for the time-shared sine Taylor sequencer.
// Numbers are Q7.25 fixed point.
package sin_pkg;

    localparam int W     = 32;
    localparam int FRAC  = 25;
    localparam int CNT_W = 19;

    // 1/3!, 1/5!, 1/7!
    localparam logic [W-1:0]    CA           = 32'h00555555;
    localparam logic [W-1:0]    CB           = 32'h00044444;
    localparam logic [W-1:0]    CC           = 32'h00001A01;
    localparam logic [FRAC-1:0] ROUND_THRESH = 25'h101B000;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ARG  = 3'd1,
        S_POW  = 3'd2,
        S_COEF = 3'd3,
        S_SUM  = 3'd4,
        S_DONE = 3'd5
    } state_t;

endpackage

// File: rtl/q725_fmul.sv
// Combinational Q7.25 multiplier. The fraction is rounded up when the discarded
// bits reach ROUND_THRESH; the result wraps modulo 2^W.
module q725_fmul
    import sin_pkg::*;
(
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    output logic [W-1:0] o_c
);

    // Product bits above FRAC+W never reach the output, so they are not formed.
    logic [FRAC+W-1:0] w_prod;
    logic              w_round;

    assign w_prod  = {{FRAC{1'b0}}, i_a} * {{FRAC{1'b0}}, i_b};
    assign w_round = (w_prod[FRAC-1:0] >= ROUND_THRESH);
    assign o_c     = w_prod[FRAC+W-1:FRAC] + {{(W-1){1'b0}}, w_round};

endmodule

// File: rtl/taylor_sin_sequencer.sv
// Time-shared sine Taylor sequencer: one rounding multiplier computes x = step*count,
// the odd powers of x, the coefficient products, and then the alternating sum.
module taylor_sin_sequencer
    import sin_pkg::*;
#(
    parameter int N_TERMS = 4
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [W-1:0]     i_step,
    input  logic [CNT_W-1:0] i_count,
    input  logic             i_half,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [W-1:0]     o_result,
    output logic             o_busy
);

    localparam int           SW        = W - 1;
    localparam logic [2:0]   POW_LAST  = 3'(2 * N_TERMS - 3);
    localparam logic [2:0]   COEF_LAST = 3'(N_TERMS - 2);

    state_t             r_state;
    state_t             w_next_state;
    logic [2:0]         r_idx;

    logic [W-1:0]       r_step;
    logic [CNT_W-1:0]   r_count;
    logic               r_half;

    logic [W-1:0]       r_x;
    logic [W-1:0]       r_p_cur;
    logic [W-1:0]       r_p3;
    logic [W-1:0]       r_p5;
    logic [W-1:0]       r_p7;
    logic [W-1:0]       r_t3;
    logic [W-1:0]       r_t5;
    logic [W-1:0]       r_t7;

    logic               r_out_valid;
    logic [W-1:0]       r_result;
    logic               r_busy;

    logic               w_accept;
    logic [W-1:0]       w_arg;
    logic [W-1:0]       w_mul_a;
    logic [W-1:0]       w_mul_b;
    logic [W-1:0]       w_mul_c;
    logic [SW-1:0]      w_sum;

    assign o_in_ready  = (r_state == S_IDLE) || ((r_state == S_DONE) && i_out_ready);
    assign w_accept    = i_in_valid && o_in_ready;
    assign o_out_valid = r_out_valid;
    assign o_result    = r_result;
    assign o_busy      = r_busy;

    assign w_arg = r_step * {{(W-CNT_W){1'b0}}, r_count};
    // Unused terms are never written and stay at their reset value of zero.
    assign w_sum = SW'((r_x - r_t3) + (r_t5 - r_t7));

    q725_fmul u_fmul (
        .i_a (w_mul_a),
        .i_b (w_mul_b),
        .o_c (w_mul_c)
    );

    always_comb begin
        w_mul_a = r_x;
        w_mul_b = r_p_cur;
        if (r_state == S_COEF) begin
            case (r_idx)
                3'd0:    begin w_mul_a = r_p3; w_mul_b = CA; end
                3'd1:    begin w_mul_a = r_p5; w_mul_b = CB; end
                default: begin w_mul_a = r_p7; w_mul_b = CC; end
            endcase
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_next_state = S_ARG;
            S_ARG:  w_next_state = S_POW;
            S_POW:  if (r_idx == POW_LAST) w_next_state = S_COEF;
            S_COEF: if (r_idx == COEF_LAST) w_next_state = S_SUM;
            S_SUM:  w_next_state = S_DONE;
            S_DONE: begin
                if (i_out_ready) w_next_state = i_in_valid ? S_ARG : S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state     <= S_IDLE;
            r_idx       <= 3'd0;
            r_step      <= '0;
            r_count     <= '0;
            r_half      <= 1'b0;
            r_x         <= '0;
            r_p_cur     <= '0;
            r_p3        <= '0;
            r_p5        <= '0;
            r_p7        <= '0;
            r_t3        <= '0;
            r_t5        <= '0;
            r_t7        <= '0;
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_busy      <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_busy  <= (w_next_state != S_IDLE);
            r_idx   <= (w_next_state != r_state) ? 3'd0 : r_idx + 3'd1;

            if (w_accept) begin
                r_step  <= i_step;
                r_count <= i_count;
                r_half  <= i_half;
            end

            case (r_state)
                S_ARG: begin
                    r_x     <= w_arg;
                    r_p_cur <= w_arg;
                end
                S_POW: begin
                    // r_idx = k-2 while forming x^k; keep the odd powers.
                    r_p_cur <= w_mul_c;
                    case (r_idx)
                        3'd1:    r_p3 <= w_mul_c;
                        3'd3:    r_p5 <= w_mul_c;
                        3'd5:    r_p7 <= w_mul_c;
                        default: ;
                    endcase
                end
                S_COEF: begin
                    case (r_idx)
                        3'd0:    r_t3 <= w_mul_c;
                        3'd1:    r_t5 <= w_mul_c;
                        3'd2:    r_t7 <= w_mul_c;
                        default: ;
                    endcase
                end
                S_SUM: begin
                    r_result    <= {r_half, w_sum};
                    r_out_valid <= 1'b1;
                end
                S_DONE: begin
                    if (i_out_ready) r_out_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_taylor_sin_sequencer.sv
// Self-checking bench for taylor_sin_sequencer: vector table, hold/back-to-back/reset
// sequences, and an N_TERMS=2 instance, all against a plain-arithmetic Taylor model.
module tb_taylor_sin_sequencer;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        in_valid, out_ready, half;
    logic [31:0] step;
    logic [18:0] count;
    logic        in_ready, out_valid, busy;
    logic [31:0] result;

    logic        in_valid2, out_ready2, half2;
    logic [31:0] step2;
    logic [18:0] count2;
    logic        in_ready2, out_valid2, busy2;
    logic [31:0] result2;

    taylor_sin_sequencer #(.N_TERMS(4)) dut (
        .i_clock(clk), .i_reset(rst), .i_in_valid(in_valid), .o_in_ready(in_ready),
        .i_step(step), .i_count(count), .i_half(half), .o_out_valid(out_valid),
        .i_out_ready(out_ready), .o_result(result), .o_busy(busy)
    );

    taylor_sin_sequencer #(.N_TERMS(2)) dut2 (
        .i_clock(clk), .i_reset(rst), .i_in_valid(in_valid2), .o_in_ready(in_ready2),
        .i_step(step2), .i_count(count2), .i_half(half2), .o_out_valid(out_valid2),
        .i_out_ready(out_ready2), .o_result(result2), .o_busy(busy2)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference: Q7.25 multiply = floor(a*b / 2^25) plus one when the remainder reaches the threshold.
    function automatic logic [31:0] m_fmul(input logic [31:0] a, input logic [31:0] b);
        logic [63:0] r, q, rem;
        r   = {32'd0, a} * {32'd0, b};
        q   = r >> 25;
        rem = r - (q << 25);
        m_fmul = q[31:0] + ((rem >= 64'h101B000) ? 32'd1 : 32'd0);
    endfunction

    // Reference: x - x^3/3! + x^5/5! - x^7/7! truncated to n terms, mod 2^32.
    function automatic logic [31:0] m_sin(input logic [31:0] s, input logic [18:0] c,
                                          input logic h, input int n);
        logic [31:0] p [1:7];
        logic [31:0] coef [1:3];
        logic [31:0] x, acc, t;
        logic [63:0] xf;
        coef[1] = 32'h00555555;
        coef[2] = 32'h00044444;
        coef[3] = 32'h00001A01;
        xf   = {32'd0, s} * {45'd0, c};
        x    = xf[31:0];
        p[1] = x;
        for (int k = 2; k <= 2 * n - 1; k++) p[k] = m_fmul(x, p[k-1]);
        acc = x;
        for (int j = 1; j < n; j++) begin
            t = m_fmul(p[2*j+1], coef[j]);
            if (j % 2 == 1) acc = acc - t;
            else            acc = acc + t;
        end
        m_sin = {h, acc[30:0]};
    endfunction

    typedef struct {
        logic [31:0] step;
        logic [18:0] count;
        logic        half;
        logic [31:0] exp;
    } vec_t;

    localparam int NV = 10;
    vec_t vecs [NV];

    // Drives one sample into the N=4 instance (which must be idle), checks latency and result.
    task automatic run_one(input string nm, input logic [31:0] s, input logic [18:0] c,
                           input logic h, input logic [31:0] exp);
        int lat;
        check({nm, "_in_ready"}, {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1; step = s; count = c; half = h;
        @(posedge clk); #1;
        in_valid = 1'b0; step = $urandom; count = 19'($urandom); half = ~h;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check({nm, "_latency"}, 32'(lat), 32'd11);
        check({nm, "_result"}, result, exp);
        @(posedge clk); #1;
        check({nm, "_drop"}, {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    logic [31:0] held, e, e2;
    int          lat, spur, d;
    logic [31:0] exp_q [$];
    vec_t        bs [8];
    int          k, got, last_cyc;
    logic        acc;

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; half = 1'b0; step = '0; count = '0;
        in_valid2 = 1'b0; out_ready2 = 1'b1; half2 = 1'b0; step2 = '0; count2 = '0;

        vecs[0] = '{32'h03243F6B, 19'd1, 1'b1, 32'h0};
        vecs[1] = '{$urandom, 19'd0, 1'b0, 32'h0};
        vecs[2] = '{32'h00000100, 19'h7FFFF, 1'b0, 32'h0};
        vecs[3] = '{32'hFFFFFFFF, 19'd3, 1'b1, 32'h0};
        for (int i = 4; i < NV; i++)
            vecs[i] = '{32'($urandom_range(32'h03243F6B, 0)), 19'($urandom_range(8, 1)),
                        1'($urandom), 32'h0};
        for (int i = 0; i < NV; i++)
            if (i != 1) vecs[i].exp = m_sin(vecs[i].step, vecs[i].count, vecs[i].half, 4);

        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        rst = 1'b0;
        @(posedge clk); #1;

        // Vector table; entry 1 (count=0) must give exactly zero.
        for (int i = 0; i < NV; i++) begin
            run_one($sformatf("vec%0d", i), vecs[i].step, vecs[i].count, vecs[i].half, vecs[i].exp);
            if (i == 0) begin
                d = int'({1'b0, result[30:0]}) - int'(32'h01FFEB08);
                check("quarter_wave_window", {31'd0, (d <= 256 && d >= -256)}, 32'd1);
                check("quarter_wave_sign", {31'd0, result[31]}, 32'd1);
            end
        end

        // Hold: result and flags stay frozen while downstream stalls; new inputs ignored.
        out_ready = 1'b0;
        e = m_sin(32'h01000000, 19'd2, 1'b1, 4);
        in_valid = 1'b1; step = 32'h01000000; count = 19'd2; half = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check("hold_latency", 32'(lat), 32'd11);
        check("hold_first", result, e);
        held = result;
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1; step = $urandom; count = 19'($urandom); half = 1'($urandom);
            @(posedge clk); #1;
            check("hold_result", result, held);
            check("hold_flags", {29'd0, out_valid, in_ready, busy}, 32'd5);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        check("hold_release", {29'd0, out_valid, in_ready, busy}, 32'd2);

        // Back-to-back: the next sample is taken in the DONE cycle, so results are
        // spaced one latency plus the DONE cycle apart.
        for (int i = 0; i < 8; i++)
            bs[i] = '{$urandom, 19'($urandom_range(4, 0)), 1'($urandom), 32'h0};
        k = 0; got = 0; last_cyc = 0;
        in_valid = 1'b1; step = bs[0].step; count = bs[0].count; half = bs[0].half;
        for (int cyc = 0; cyc < 200 && got < 8; cyc++) begin
            acc = in_ready && in_valid;
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("b2b_unexpected", 32'd1, 32'd0);
                end else begin
                    check("b2b_result", result, exp_q.pop_front());
                end
                if (got > 0) check("b2b_spacing", 32'(cyc - last_cyc), 32'd12);
                last_cyc = cyc;
                got++;
            end
            @(posedge clk); #1;
            if (acc) begin
                exp_q.push_back(m_sin(step, count, half, 4));
                k++;
                if (k < 8) begin
                    step = bs[k].step; count = bs[k].count; half = bs[k].half;
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        check("b2b_count", 32'(got), 32'd8);
        repeat (2) @(posedge clk);
        #1;

        // Reset during the third POW cycle aborts the sample.
        in_valid = 1'b1; step = 32'h03243F6B; count = 19'd1; half = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_flags", {29'd0, out_valid, in_ready, busy}, 32'd2);
        check("abort_result", result, 32'd0);
        spur = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (out_valid) spur++;
        end
        check("abort_no_output", 32'(spur), 32'd0);

        // Two-term build.
        e2 = m_sin(32'h03243F6B, 19'd1, 1'b0, 2);
        check("n2_in_ready", {31'd0, in_ready2}, 32'd1);
        in_valid2 = 1'b1; step2 = 32'h03243F6B; count2 = 19'd1; half2 = 1'b0;
        @(posedge clk); #1;
        in_valid2 = 1'b0; step2 = $urandom;
        lat = 0;
        while (!out_valid2 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check("n2_latency", 32'(lat), 32'd5);
        check("n2_result", result2, e2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
